id_ex_stage: RTL and testbench

- ID/EX pipeline stage that sits directly upstream of the ALU.
- Registers the decoded ALU controls, operands and register addresses, and forwards EX/MEM and MEM/WB results into the operands.
- Selects PC, immediate or zero as ALU operands, and drives i_opsel/i_sub/i_unsigned/i_arith/i_op1/i_op2 of the ALU.
- Detects load-use hazards and inserts its own bubble; supports stall and flush.

---
 rtl/id_ex_stage.sv | 162 ++++++++++++++++
 tb/tb_id_ex_stage.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded controls and operands,
// forwards EX/MEM and MEM/WB results, and inserts a bubble on load-use hazards.
module id_ex_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic            i_valid,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_rs1_data,
    input  logic [XLEN-1:0] i_rs2_data,
    input  logic [XLEN-1:0] i_imm,
    input  logic [4:0]      i_rs1_addr,
    input  logic [4:0]      i_rs2_addr,
    input  logic [4:0]      i_rd_addr,
    input  logic [2:0]      i_opsel,
    input  logic            i_sub,
    input  logic            i_unsigned,
    input  logic            i_arith,
    input  logic            i_op1_pc,
    input  logic            i_op1_zero,
    input  logic            i_op2_imm,
    input  logic            i_reg_wen,
    input  logic            i_mem_read,
    input  logic            i_mem_write,
    input  logic [4:0]      i_exmem_rd,
    input  logic            i_exmem_wen,
    input  logic [XLEN-1:0] i_exmem_result,
    input  logic [4:0]      i_memwb_rd,
    input  logic            i_memwb_wen,
    input  logic [XLEN-1:0] i_memwb_result,
    output logic            o_valid,
    output logic [2:0]      o_opsel,
    output logic            o_sub,
    output logic            o_unsigned,
    output logic            o_arith,
    output logic [XLEN-1:0] o_op1,
    output logic [XLEN-1:0] o_op2,
    output logic [XLEN-1:0] o_store_data,
    output logic [XLEN-1:0] o_pc,
    output logic [4:0]      o_rd_addr,
    output logic            o_reg_wen,
    output logic            o_mem_read,
    output logic            o_mem_write,
    output logic            o_load_use
);

    typedef struct packed {
        logic            valid;
        logic [2:0]      opsel;
        logic            sub;
        logic            uns;
        logic            arith;
        logic            op1_pc;
        logic            op1_zero;
        logic            op2_imm;
        logic            reg_wen;
        logic            mem_read;
        logic            mem_write;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
    } id_ex_t;

    id_ex_t          r_q;
    id_ex_t          w_id;
    logic [XLEN-1:0] w_fwd_rs1;
    logic [XLEN-1:0] w_fwd_rs2;
    logic            w_exmem_hit1;
    logic            w_exmem_hit2;
    logic            w_memwb_hit1;
    logic            w_memwb_hit2;
    logic            w_load_use;

    always_comb begin
        w_id          = '0;
        w_id.valid    = i_valid;
        w_id.opsel    = i_opsel;
        w_id.sub      = i_sub;
        w_id.uns      = i_unsigned;
        w_id.arith    = i_arith;
        w_id.op1_pc   = i_op1_pc;
        w_id.op1_zero = i_op1_zero;
        w_id.op2_imm  = i_op2_imm;
        w_id.reg_wen  = i_reg_wen;
        w_id.mem_read = i_mem_read;
        w_id.mem_write = i_mem_write;
        w_id.pc       = i_pc;
        w_id.rs1_data = i_rs1_data;
        w_id.rs2_data = i_rs2_data;
        w_id.imm      = i_imm;
        w_id.rs1_addr = i_rs1_addr;
        w_id.rs2_addr = i_rs2_addr;
        w_id.rd_addr  = i_rd_addr;
    end

    // x0 never forwards; EX/MEM outranks MEM/WB as the younger result
    assign w_exmem_hit1 = i_exmem_wen && (i_exmem_rd != 5'd0) && (i_exmem_rd == r_q.rs1_addr);
    assign w_exmem_hit2 = i_exmem_wen && (i_exmem_rd != 5'd0) && (i_exmem_rd == r_q.rs2_addr);
    assign w_memwb_hit1 = i_memwb_wen && (i_memwb_rd != 5'd0) && (i_memwb_rd == r_q.rs1_addr);
    assign w_memwb_hit2 = i_memwb_wen && (i_memwb_rd != 5'd0) && (i_memwb_rd == r_q.rs2_addr);

    always_comb begin
        w_fwd_rs1 = r_q.rs1_data;
        if (w_exmem_hit1) begin
            w_fwd_rs1 = i_exmem_result;
        end else if (w_memwb_hit1) begin
            w_fwd_rs1 = i_memwb_result;
        end
    end

    always_comb begin
        w_fwd_rs2 = r_q.rs2_data;
        if (w_exmem_hit2) begin
            w_fwd_rs2 = i_exmem_result;
        end else if (w_memwb_hit2) begin
            w_fwd_rs2 = i_memwb_result;
        end
    end

    assign w_load_use = r_q.valid && r_q.mem_read && (r_q.rd_addr != 5'd0) &&
                        ((r_q.rd_addr == i_rs1_addr) || (r_q.rd_addr == i_rs2_addr)) &&
                        i_valid && !i_flush;

    // During a stall the operand data keeps absorbing forwards so a retiring writeback is not lost
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_flush) begin
            r_q <= '0;
        end else if (i_stall) begin
            r_q.rs1_data <= w_fwd_rs1;
            r_q.rs2_data <= w_fwd_rs2;
        end else if (w_load_use) begin
            r_q <= '0;
        end else begin
            r_q <= w_id;
        end
    end

    assign o_valid      = r_q.valid;
    assign o_opsel      = r_q.opsel;
    assign o_sub        = r_q.sub;
    assign o_unsigned   = r_q.uns;
    assign o_arith      = r_q.arith;
    assign o_pc         = r_q.pc;
    assign o_rd_addr    = r_q.rd_addr;
    assign o_reg_wen    = r_q.reg_wen;
    assign o_mem_read   = r_q.mem_read;
    assign o_mem_write  = r_q.mem_write;
    assign o_load_use   = w_load_use;
    assign o_op1        = r_q.op1_zero ? '0 : (r_q.op1_pc ? r_q.pc : w_fwd_rs1);
    assign o_op2        = r_q.op2_imm ? r_q.imm : w_fwd_rs2;
    assign o_store_data = w_fwd_rs2;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: stimulus queues hand-computed expectations per
// sample slot; a negedge monitor pops and compares them against the DUT outputs.
module tb_id_ex_stage;

    typedef enum int {
        F_VALID, F_OP1, F_OP2, F_STORE, F_LU, F_REGWEN,
        F_SUB, F_OPSEL, F_MEMREAD, F_PC
    } field_e;

    typedef struct {
        string       name;
        int          slot;
        field_e      f;
        logic [31:0] exp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, flush, valid;
    logic [31:0] pc, rs1_data, rs2_data, imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic [2:0]  opsel;
    logic        sub, uns, arith, op1_pc, op1_zero, op2_imm;
    logic        reg_wen, mem_read, mem_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_wen, memwb_wen;
    logic [31:0] exmem_res, memwb_res;

    logic        o_valid, o_sub, o_unsigned, o_arith;
    logic [2:0]  o_opsel;
    logic [31:0] o_op1, o_op2, o_store_data, o_pc;
    logic [4:0]  o_rd_addr;
    logic        o_reg_wen, o_mem_read, o_mem_write, o_load_use;

    exp_t q[$];
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.XLEN(32)) dut (
        .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_flush(flush), .i_valid(valid),
        .i_pc(pc), .i_rs1_data(rs1_data), .i_rs2_data(rs2_data), .i_imm(imm),
        .i_rs1_addr(rs1_addr), .i_rs2_addr(rs2_addr), .i_rd_addr(rd_addr),
        .i_opsel(opsel), .i_sub(sub), .i_unsigned(uns), .i_arith(arith),
        .i_op1_pc(op1_pc), .i_op1_zero(op1_zero), .i_op2_imm(op2_imm),
        .i_reg_wen(reg_wen), .i_mem_read(mem_read), .i_mem_write(mem_write),
        .i_exmem_rd(exmem_rd), .i_exmem_wen(exmem_wen), .i_exmem_result(exmem_res),
        .i_memwb_rd(memwb_rd), .i_memwb_wen(memwb_wen), .i_memwb_result(memwb_res),
        .o_valid(o_valid), .o_opsel(o_opsel), .o_sub(o_sub), .o_unsigned(o_unsigned),
        .o_arith(o_arith), .o_op1(o_op1), .o_op2(o_op2), .o_store_data(o_store_data),
        .o_pc(o_pc), .o_rd_addr(o_rd_addr), .o_reg_wen(o_reg_wen),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write), .o_load_use(o_load_use)
    );

    function automatic logic [31:0] actual(field_e f);
        case (f)
            F_VALID:   return {31'd0, o_valid};
            F_OP1:     return o_op1;
            F_OP2:     return o_op2;
            F_STORE:   return o_store_data;
            F_LU:      return {31'd0, o_load_use};
            F_REGWEN:  return {31'd0, o_reg_wen};
            F_SUB:     return {31'd0, o_sub};
            F_OPSEL:   return {29'd0, o_opsel};
            F_MEMREAD: return {31'd0, o_mem_read};
            default:   return o_pc;
        endcase
    endfunction

    // Monitor: each negedge is one sample slot
    initial begin
        forever begin
            @(negedge clk);
            cyc = cyc + 1;
            while (q.size() > 0 && q[0].slot <= cyc) begin
                exp_t e;
                logic [31:0] a;
                e = q.pop_front();
                n_checks = n_checks + 1;
                if (e.slot < cyc) begin
                    n_fail = n_fail + 1;
                    $display("FAIL %s: slot %0d missed (now %0d), expected %h", e.name, e.slot, cyc, e.exp);
                end else begin
                    a = actual(e.f);
                    if (a !== e.exp) begin
                        n_fail = n_fail + 1;
                        $display("FAIL %s: got %h expected %h (slot %0d)", e.name, a, e.exp, cyc);
                    end
                end
            end
        end
    end

    task automatic expect_now(input string n, input field_e f, input logic [31:0] v);
        exp_t e;
        e.name = n;
        e.slot = cyc + 1;
        e.f    = f;
        e.exp  = v;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_id();
        valid = 0; pc = '0; rs1_data = '0; rs2_data = '0; imm = '0;
        rs1_addr = '0; rs2_addr = '0; rd_addr = '0; opsel = '0;
        sub = 0; uns = 0; arith = 0; op1_pc = 0; op1_zero = 0; op2_imm = 0;
        reg_wen = 0; mem_read = 0; mem_write = 0;
    endtask

    task automatic clear_fwd();
        exmem_rd = '0; exmem_wen = 0; exmem_res = '0;
        memwb_rd = '0; memwb_wen = 0; memwb_res = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1; stall = 0; flush = 0;
        clear_id();
        clear_fwd();

        step();
        expect_now("reset_valid", F_VALID, 32'd0);
        expect_now("reset_op1", F_OP1, 32'd0);
        expect_now("reset_op2", F_OP2, 32'd0);
        expect_now("reset_store", F_STORE, 32'd0);
        expect_now("reset_lu", F_LU, 32'd0);
        expect_now("reset_regwen", F_REGWEN, 32'd0);
        step();
        rst = 0;

        // capture
        clear_id();
        valid = 1; sub = 1; rs1_data = 100; rs2_data = 50;
        rs1_addr = 1; rs2_addr = 2; rd_addr = 3; reg_wen = 1;
        step();
        expect_now("cap_valid", F_VALID, 32'd1);
        expect_now("cap_op1", F_OP1, 32'd100);
        expect_now("cap_op2", F_OP2, 32'd50);
        expect_now("cap_store", F_STORE, 32'd50);
        expect_now("cap_sub", F_SUB, 32'd1);
        expect_now("cap_opsel", F_OPSEL, 32'd0);
        expect_now("cap_regwen", F_REGWEN, 32'd1);

        // forwarding priority
        clear_id();
        valid = 1; rs1_addr = 5; rs1_data = 32'h55; rs2_addr = 6; rs2_data = 32'h60;
        step();
        exmem_rd = 5; exmem_wen = 1; exmem_res = 32'h11;
        memwb_rd = 5; memwb_wen = 1; memwb_res = 32'h22;
        expect_now("fwd_exmem_op1", F_OP1, 32'h11);
        expect_now("fwd_none_op2", F_OP2, 32'h60);
        step();
        exmem_wen = 0;
        expect_now("fwd_memwb_op1", F_OP1, 32'h22);
        step();
        exmem_wen = 1; exmem_rd = 0; memwb_rd = 0;
        expect_now("fwd_x0_op1", F_OP1, 32'h55);
        step();
        exmem_rd = 6;
        expect_now("fwd_rs2_op2", F_OP2, 32'h11);
        expect_now("fwd_rs2_store", F_STORE, 32'h11);
        expect_now("fwd_rs2_op1", F_OP1, 32'h55);
        step();
        clear_fwd();

        // load-use with rd=7
        clear_id();
        valid = 1; mem_read = 1; rd_addr = 7; reg_wen = 1; rs1_addr = 1; rs2_addr = 2;
        step();
        clear_id();
        valid = 1; rs1_addr = 1; rs2_addr = 7; rd_addr = 8; reg_wen = 1;
        expect_now("lu_detect", F_LU, 32'd1);
        step();
        expect_now("lu_bubble_valid", F_VALID, 32'd0);
        expect_now("lu_bubble_regwen", F_REGWEN, 32'd0);
        expect_now("lu_bubble_memread", F_MEMREAD, 32'd0);
        expect_now("lu_after_bubble", F_LU, 32'd0);
        step();

        // load with rd=0 never hazards
        clear_id();
        valid = 1; mem_read = 1; rd_addr = 0; reg_wen = 1;
        step();
        clear_id();
        valid = 1; rs1_addr = 0; rs2_addr = 0;
        expect_now("lu_rd0_memread", F_MEMREAD, 32'd1);
        expect_now("lu_rd0", F_LU, 32'd0);
        step();

        // i_valid gating, stall hold, flush masking
        clear_id();
        valid = 1; mem_read = 1; rd_addr = 7; reg_wen = 1;
        step();
        stall = 1;
        clear_id();
        valid = 0; rs1_addr = 7;
        expect_now("lu_id_invalid", F_LU, 32'd0);
        step();
        valid = 1;
        expect_now("lu_under_stall", F_LU, 32'd1);
        expect_now("stall_hold_valid", F_VALID, 32'd1);
        step();
        flush = 1;
        expect_now("lu_flush_mask", F_LU, 32'd0);
        step();
        flush = 0; stall = 0;
        expect_now("flush_stall_valid", F_VALID, 32'd0);
        expect_now("flush_stall_regwen", F_REGWEN, 32'd0);
        expect_now("flush_stall_memread", F_MEMREAD, 32'd0);
        expect_now("flush_stall_lu", F_LU, 32'd0);
        step();

        // stall refresh from a one-cycle MEM/WB pulse
        clear_id();
        valid = 1; rs1_addr = 3; rs1_data = 32'hAAAA; reg_wen = 1;
        step();
        expect_now("sr_base", F_OP1, 32'hAAAA);
        step();
        stall = 1; rs1_data = 32'h1234;
        memwb_rd = 3; memwb_wen = 1; memwb_res = 32'hBEEF;
        expect_now("sr_fwd", F_OP1, 32'hBEEF);
        step();
        clear_fwd();
        expect_now("sr_kept1", F_OP1, 32'hBEEF);
        step();
        expect_now("sr_kept2", F_OP1, 32'hBEEF);
        expect_now("sr_valid", F_VALID, 32'd1);
        step();
        stall = 0;
        expect_now("sr_kept3", F_OP1, 32'hBEEF);
        step();
        expect_now("sr_release", F_OP1, 32'h1234);

        // operand select, then asynchronous reset mid-stall
        clear_id();
        valid = 1; op1_pc = 1; pc = 32'h1000; op2_imm = 1; imm = 32'hFFFFF800;
        rs1_data = 9; rs2_addr = 4; rs2_data = 32'h77;
        step();
        expect_now("sel_op1_pc", F_OP1, 32'h1000);
        expect_now("sel_op2_imm", F_OP2, 32'hFFFFF800);
        expect_now("sel_store_reg", F_STORE, 32'h77);
        expect_now("sel_pc", F_PC, 32'h1000);
        op1_zero = 1;
        step();
        expect_now("sel_op1_zero", F_OP1, 32'd0);
        step();
        stall = 1; rst = 1;
        expect_now("arst_valid", F_VALID, 32'd0);
        expect_now("arst_op1", F_OP1, 32'd0);
        expect_now("arst_op2", F_OP2, 32'd0);
        expect_now("arst_store", F_STORE, 32'd0);
        step();
        rst = 0;
        step();
        expect_now("arst_stall_discard", F_VALID, 32'd0);
        step();
        stall = 0;
        step();
        expect_now("post_reset_capture", F_VALID, 32'd1);

        for (int i = 0; i < 20 && q.size() > 0; i++) begin
            @(negedge clk);
        end
        #1;
        if (q.size() > 0) begin
            n_checks = n_checks + q.size();
            n_fail = n_fail + q.size();
            $display("FAIL drain: %0d expectations never sampled, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
